// File: rtl/nbody_pkg.sv
// Shared types and constants for the getAccl pair scheduler.
// Holds sizing, latencies, FSM state enum and the result tag.
package nbody_pkg;

  localparam int IDX_W        = 4;
  localparam int N_MAX        = 16;
  localparam int ACCL_LATENCY = 122;
  localparam int BODY_MEM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] i_idx;
    logic             first;
    logic             last;
  } accl_tag_t;

endpackage

// File: rtl/accl_pair_scheduler_tag_pipe.sv
// accl_tag_pipe: fixed-depth shift register of result tags.
// Ports: clk, rst, tag_i in; tap_o (after TAP stages), out_o (final), busy_o.
module accl_tag_pipe
  import nbody_pkg::*;
#(
  parameter int DEPTH = 123,
  parameter int TAP   = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  accl_tag_t tag_i,
  output accl_tag_t tap_o,
  output accl_tag_t out_o,
  output logic      busy_o
);

  accl_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign tap_o = pipe_q[TAP-1];
  assign out_o = pipe_q[DEPTH-1];

  // Final stage excluded: the run may finish the cycle the last
  // result is presented, so done lands one cycle after it.
  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k < DEPTH-1; k++) busy_o = busy_o | pipe_q[k].valid;
  end

endmodule

// File: rtl/accl_pair_scheduler.sv
// Issues every ordered pair (i,j), i!=j, one per cycle into getAccl
// and tags results. Ports: clk, rst, start, n_bodies -> busy, done,
// rd_en/rd_i_idx/rd_j_idx, pipe_valid, res_valid/res_i_idx/res_first/
// res_last. Macro ACCL_SCHED_PERF_EN adds perf_cycles.
module accl_pair_scheduler
  import nbody_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   n_bodies,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_i_idx,
  output logic [IDX_W-1:0] rd_j_idx,
  output logic             pipe_valid,
  output logic             res_valid,
  output logic [IDX_W-1:0] res_i_idx,
  output logic             res_first,
  output logic             res_last
`ifdef ACCL_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] TWO  = (IDX_W+1)'(2);
  localparam logic [IDX_W:0] NMAX = (IDX_W+1)'(N_MAX);

  sched_state_e     state_q, state_d;
  logic [IDX_W:0]   n_q, n_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;

  logic [IDX_W:0]   n_clamp, nm1, nm2, i_w, j_w, jn;
  logic             pipe_busy;
  accl_tag_t        tag_in, tag_tap, tag_out;

  assign n_clamp = (n_bodies > NMAX) ? NMAX : n_bodies;
  assign nm1     = n_q - ONE;
  assign nm2     = n_q - TWO;
  assign i_w     = {1'b0, i_q};
  assign j_w     = {1'b0, j_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    rd_en   = 1'b0;
    jn      = j_w + ONE;
    if (jn == i_w) jn = j_w + TWO;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_clamp;
          i_d     = '0;
          j_d     = IDX_W'(1);
          state_d = (n_clamp >= TWO) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (i_w == nm1 && j_w == nm2) begin
          state_d = DRAIN;
        end else if (jn >= n_q) begin
          // i+1 is never 0 here, so the row always restarts at j=0
          i_d = i_q + IDX_W'(1);
          j_d = '0;
        end else begin
          j_d = jn[IDX_W-1:0];
        end
      end
      DRAIN: begin
        if (!pipe_busy) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign rd_i_idx = rd_en ? i_q : '0;
  assign rd_j_idx = rd_en ? j_q : '0;

  // Invalid slots carry all-zero tags so res_* stay 0 between results
  always_comb begin
    tag_in       = '0;
    tag_in.valid = rd_en;
    if (rd_en) begin
      tag_in.i_idx = i_q;
      tag_in.first = (j_w == ((i_q == '0) ? ONE : '0));
      tag_in.last  = (j_w == ((i_w == nm1) ? nm2 : nm1));
    end
  end

  accl_tag_pipe #(
    .DEPTH (BODY_MEM_LAT + ACCL_LATENCY),
    .TAP   (BODY_MEM_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_i  (tag_in),
    .tap_o  (tag_tap),
    .out_o  (tag_out),
    .busy_o (pipe_busy)
  );

  assign pipe_valid = tag_tap.valid;
  assign res_valid  = tag_out.valid;
  assign res_i_idx  = tag_out.i_idx;
  assign res_first  = tag_out.first;
  assign res_last   = tag_out.last;

`ifdef ACCL_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (state_q == IDLE) begin
      if (start) perf_q <= '0;
    end else if (perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_accl_pair_scheduler.sv
// Directed testbench for accl_pair_scheduler.
// Checks ordering, tags, result timing, reset abort and clamping.
module tb_accl_pair_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] n_bodies;
  logic       busy, done, rd_en, pipe_valid;
  logic [3:0] rd_i_idx, rd_j_idx, res_i_idx;
  logic       res_valid, res_first, res_last;
`ifdef ACCL_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accl_pair_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_bodies   (n_bodies),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_i_idx   (rd_i_idx),
    .rd_j_idx   (rd_j_idx),
    .pipe_valid (pipe_valid),
    .res_valid  (res_valid),
    .res_i_idx  (res_i_idx),
    .res_first  (res_first),
    .res_last   (res_last)
`ifdef ACCL_SCHED_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a run with n_bodies=nreq (effective count n); optionally
  // pulse a stray start in cycle 'stray' after acceptance.
  task automatic run(input int nreq, input int n, input int stray);
    int ei [256];
    int ej [256];
    bit ef [256];
    bit el [256];
    int m, k, r, cyc, dc, bb;
    bit row_first, prev_rd;
    m = 0;
    for (int i = 0; i < n; i++) begin
      row_first = 1'b1;
      for (int j = 0; j < n; j++) begin
        if (j != i) begin
          ei[m] = i; ej[m] = j;
          ef[m] = row_first; el[m] = 1'b0;
          row_first = 1'b0;
          m++;
        end
      end
      if (m > 0 && !row_first) el[m-1] = 1'b1;
    end
    @(negedge clk);
    n_bodies = 5'(nreq);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    n_bodies = 5'd7;
    cyc = 1; k = 0; r = 0; dc = 0; bb = 0; prev_rd = 1'b0;
    while (dc == 0 && cyc < 700) begin
      start = (cyc == stray);
      if (!busy) bb++;
      chk("pipe_valid", 64'(pipe_valid), 64'(prev_rd));
      prev_rd = rd_en;
      if (rd_en) begin
        chk("rd_cycle", 64'(cyc), 64'(k + 1));
        if (k < m) begin
          chk("rd_i_idx", 64'(rd_i_idx), 64'(ei[k]));
          chk("rd_j_idx", 64'(rd_j_idx), 64'(ej[k]));
        end
        k++;
      end
      if (res_valid) begin
        chk("res_cycle", 64'(cyc), 64'(r + 124));
        if (r < m) begin
          chk("res_i_idx", 64'(res_i_idx), 64'(ei[r]));
          chk("res_first", 64'(res_first), 64'(ef[r]));
          chk("res_last", 64'(res_last), 64'(el[r]));
        end
        r++;
      end
      if (done) dc = cyc;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk("issue_count", 64'(k), 64'(m));
    chk("res_count", 64'(r), 64'(m));
    chk("done_cycle", 64'(dc), 64'((n < 2) ? 1 : m + 124));
    chk("busy_in_run", 64'(bb), 64'(0));
    @(posedge clk);
    #1;
    chk("busy_after", 64'(busy), 64'(0));
    chk("done_after", 64'(done), 64'(0));
  endtask

  initial begin
    int nres, ndone;
    rst      = 1'b1;
    start    = 1'b0;
    n_bodies = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rd_en", 64'(rd_en), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_pipe_valid", 64'(pipe_valid), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run(4, 4, 0);
    run(1, 1, 0);
    run(0, 0, 0);
    run(2, 2, 0);
    run(4, 4, 5);

    // Abort an N=4 run with reset in cycle 6
    @(negedge clk);
    n_bodies = 5'd4;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_abort_pipe_valid", 64'(pipe_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_rd_en", 64'(rd_en), 64'(0));
    chk("abort_rd_j", 64'(rd_j_idx), 64'(0));
    chk("abort_pipe_valid", 64'(pipe_valid), 64'(0));
    chk("abort_res_valid", 64'(res_valid), 64'(0));
    @(posedge clk);
    #1;
    rst  = 1'b0;
    nres = 0; ndone = 0;
    for (int c = 0; c < 200; c++) begin
      if (res_valid) nres++;
      if (done) ndone++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_res", 64'(nres), 64'(0));
    chk("abort_no_done", 64'(ndone), 64'(0));
    run(3, 3, 0);

    // Clamp: 20 requested, 16 used
    run(20, 16, 0);
`ifdef ACCL_SCHED_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(364));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accl_pair_scheduler.md
Name: accl_pair_scheduler

Overview:
- Sequences all ordered body pairs (i, j), i != j, through the fixed-latency getAccl datapath (LATENCY = 122 cycles).
- Drives read addresses into the body-state memory, which has a 1-cycle registered read.
- Carries a tag (i index, first/last flags) alongside each issued pair so the downstream per-body accumulator knows which body each ax/ay result belongs to.
- getAccl has no enable, so issue is never stalled; one pair is issued per cycle.

Parameters:
- N_MAX, 16, maximum bodies supported.
- IDX_W, 4, body index width; N_MAX <= 2**IDX_W.
- LATENCY, 122, getAccl input-to-output latency in cycles.
- MEM_LAT, 1, body-memory read latency in cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request; sampled only in IDLE
- n_bodies  in  IDX_W+1  body count for the run; latched at start
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  single-cycle pulse at end of run
- rd_en  out  1  body-memory read strobe
- rd_i_idx  out  IDX_W  address of body i (feeds x1, y1, z1)
- rd_j_idx  out  IDX_W  address of body j (feeds x2, y2, m2)
- pipe_valid  out  1  getAccl inputs valid this cycle (rd_en delayed MEM_LAT)
- res_valid  out  1  ax/ay valid this cycle
- res_i_idx  out  IDX_W  body index the result belongs to
- res_first  out  1  first result for res_i_idx (accumulator clears)
- res_last  out  1  last result for res_i_idx (accumulator writes back)

Behaviour:
- Reset: all outputs 0; state IDLE; every delay-line valid bit cleared.
- Reset mid-run: the run is abandoned. No res_valid or done is produced for in-flight pairs.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches N = min(n_bodies, N_MAX).
  - If N >= 2, go to ISSUE with i=0, j=1.
  - If N < 2, go to DONE with no issue.
- ISSUE:
  - rd_en=1 every cycle.
  - Ordering: j increments; j==i is skipped. When j passes N-1, j wraps to 0 (or to 1 if the new i is 0) and i increments.
  - After pair (N-1, N-2) is issued, go to DRAIN.
- DRAIN: wait until the delay line holds no valid entry, then go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- Issue count is exactly N*(N-1) consecutive cycles; no bubbles.
- Tag flags at issue:
  - first = (j == (i==0 ? 1 : 0)).
  - last = (j == (i==N-1 ? N-2 : N-1)).
- Tag delay line: depth MEM_LAT+LATENCY, carrying {valid, i, first, last}.
  - pipe_valid is the valid bit at tap MEM_LAT.
  - res_* outputs are the final tap.
  - res_valid for a pair issued at cycle t asserts at t+MEM_LAT+LATENCY.
- Result timing: the first result arrives 1+MEM_LAT+LATENCY cycles after the start-sampling edge; done follows one cycle after the final res_valid.
- start while busy is ignored. start in the DONE cycle is ignored; it is sampled again in IDLE.
- n_bodies changes during a run have no effect.

Optional Feature:
- Macro: ACCL_SCHED_PERF_EN.
- Defined: adds output perf_cycles [31:0].
  - Counts cycles from start acceptance to done inclusive; holds after done.
  - Saturates at all-ones; cleared by rst and on each accepted start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package nbody_pkg holds:
  - IDX_W, N_MAX, ACCL_LATENCY=122, BODY_MEM_LAT=1.
  - Typedef sched_state_e (enum IDLE/ISSUE/DRAIN/DONE).
  - Packed struct accl_tag_t {valid, i_idx, first, last}.
- One sub-module, accl_tag_pipe: parameterised-depth shift register of accl_tag_t with async clear, exposing the MEM_LAT tap and the final tap.

Test Plan:
- N=4, start at edge T:
  - rd_en at T+1..T+12.
  - (i,j) sequence (0,1)(0,2)(0,3)(1,0)(1,2)(1,3)(2,0)(2,1)(2,3)(3,0)(3,1)(3,2).
  - res_valid T+124..T+135 with matching i; first on entries 1,4,7,10; last on entries 3,6,9,12.
  - done at T+136.
- N=1 and N=0: no rd_en or res_valid; done pulses at T+1; busy high only at T+1.
- N=2: pairs (0,1),(1,0) with first=last=1 on both; res_valid at T+124 and T+125; done at T+126.
- start pulsed at T+5 during an N=4 run: ignored; sequence identical to the first scenario.
- rst asserted at T+6 of an N=4 run: all outputs 0 immediately; no res_valid in the next 200 cycles; a new start (N=3) then yields 6 results.
- n_bodies=20 with N_MAX=16: clamped to 16; 240 issues; done at T+1+1+122+240. With ACCL_SCHED_PERF_EN, perf_cycles reads 364.
